decode_issue: RTL and testbench

- Decode/issue stage sitting directly upstream of the execute ALU in the RV32 core.
- Accepts a fetched instruction with a valid/ready handshake and decodes the RV32I register-register, register-immediate, LUI and AUIPC classes.
- Selects operands from the register-file read data, immediate or PC.
- Registers the operands and ALU control into one output pipeline stage that drives both ALU datapaths directly.

---
 rtl/decode_issue.sv | 170 +++++++++++++++++
 tb/tb_decode_issue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// RV32I decode/issue stage: decodes OP, OP-IMM, LUI and AUIPC, selects operands
// and registers them with ALU control into a single valid/ready output stage.
module decode_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic [1:0]      alu_op,
  output logic            alt_op,
  output logic [1:0]      alu2_op,
  output logic            alt2_op,
  output logic            res_sel,
  output logic [4:0]      rd,
  output logic            wb_en,
  output logic            illegal,
  output logic [XLEN-1:0] out_pc
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd_idx;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] u_imm;
  logic [XLEN-1:0] shamt;
  logic            accept;

  logic [XLEN-1:0] d_op_a;
  logic [XLEN-1:0] d_op_b;
  logic [1:0]      d_alu_op;
  logic            d_alt_op;
  logic [1:0]      d_alu2_op;
  logic            d_alt2_op;
  logic            d_res_sel;
  logic            d_illegal;
  logic            is_op;
  logic            is_arith;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign rd_idx   = in_instr[11:7];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign i_imm    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign u_imm    = {in_instr[31:12], 12'b0};
  assign shamt    = {{(XLEN-5){1'b0}}, in_instr[24:20]};

  assign in_ready = (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    d_op_a    = '0;
    d_op_b    = '0;
    d_alu_op  = 2'd0;
    d_alt_op  = 1'b0;
    d_alu2_op = 2'd0;
    d_alt2_op = 1'b0;
    d_res_sel = 1'b0;
    d_illegal = 1'b1;
    is_op     = 1'b0;
    is_arith  = 1'b0;

    case (opcode)
      OPC_OP: begin
        is_op     = 1'b1;
        is_arith  = 1'b1;
        d_op_a    = rs1_data;
        d_op_b    = rs2_data;
        d_illegal = !((funct7 == F7_ZERO) ||
                      ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        is_arith = 1'b1;
        d_op_a   = rs1_data;
        // Shifts carry only the shift amount; funct7 occupies the rest of the immediate
        if (funct3 == 3'b001) begin
          d_op_b    = shamt;
          d_illegal = (funct7 != F7_ZERO);
        end else if (funct3 == 3'b101) begin
          d_op_b    = shamt;
          d_illegal = !((funct7 == F7_ZERO) || (funct7 == F7_ALT));
        end else begin
          d_op_b    = i_imm;
          d_illegal = 1'b0;
        end
      end
      OPC_LUI: begin
        d_op_b    = u_imm;
        d_alu2_op = 2'd3;
        d_res_sel = 1'b1;
        d_illegal = 1'b0;
      end
      OPC_AUIPC: begin
        d_op_a    = in_pc;
        d_op_b    = u_imm;
        d_illegal = 1'b0;
      end
      default: ;
    endcase

    if (is_arith) begin
      case (funct3)
        3'b000: d_alt_op = is_op && funct7[5];
        3'b001: begin d_alu2_op = 2'd0; d_res_sel = 1'b1; end
        3'b010: begin d_alu2_op = 2'd1; d_alt2_op = 1'b1; d_res_sel = 1'b1; end
        3'b011: begin d_alu2_op = 2'd1; d_res_sel = 1'b1; end
        3'b100: d_alu_op = 2'd2;
        3'b101: begin d_alu2_op = 2'd2; d_alt2_op = funct7[5]; d_res_sel = 1'b1; end
        3'b110: d_alu_op = 2'd3;
        default: d_alu_op = 2'd1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      alu_op    <= 2'd0;
      alt_op    <= 1'b0;
      alu2_op   <= 2'd0;
      alt2_op   <= 1'b0;
      res_sel   <= 1'b0;
      rd        <= 5'd0;
      wb_en     <= 1'b0;
      illegal   <= 1'b0;
      out_pc    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      op_a      <= d_op_a;
      op_b      <= d_op_b;
      alu_op    <= d_alu_op;
      alt_op    <= d_alt_op;
      alu2_op   <= d_alu2_op;
      alt2_op   <= d_alt2_op;
      res_sel   <= d_res_sel;
      rd        <= rd_idx;
      wb_en     <= !d_illegal && (rd_idx != 5'd0);
      illegal   <= d_illegal;
      out_pc    <= in_pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Randomized scoreboard bench for decode_issue: a driver pushes expected results
// from a reference decoder, a negedge monitor pops and compares output beats.
module tb_decode_issue;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  aop;
    logic        alt;
    logic [1:0]  a2op;
    logic        alt2;
    logic        rsel;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
    logic [31:0] pc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] op_a, op_b, out_pc;
  logic [1:0]  alu_op, alu2_op;
  logic        alt_op, alt2_op, res_sel, wb_en, illegal;
  logic [4:0]  rd;

  int n_chk = 0;
  int n_fail = 0;
  res_t exp_q[$];
  bit   exp_valid = 0;
  bit   acc_flag = 0;
  bit   mon_en = 0;

  decode_issue #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .op_a(op_a), .op_b(op_b),
    .alu_op(alu_op), .alt_op(alt_op), .alu2_op(alu2_op), .alt2_op(alt2_op),
    .res_sel(res_sel), .rd(rd), .wb_en(wb_en), .illegal(illegal), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  res_t dut_res;
  assign dut_res = {op_a, op_b, alu_op, alt_op, alu2_op, alt2_op, res_sel, rd, wb_en, illegal, out_pc};

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference decoder written from the instruction-set rules
  function automatic res_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2);
    res_t r;
    int f3, f7, opc;
    bit arith;
    opc = int'(ins[6:0]);
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    r = '0;
    r.rd = ins[11:7];
    r.pc = pc;
    r.ill = 1;
    arith = 0;
    if (opc == 'h33) begin
      arith = 1; r.a = r1; r.b = r2;
      r.ill = !(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5)));
    end else if (opc == 'h13) begin
      arith = 1; r.a = r1;
      if (f3 == 1 || f3 == 5) r.b = 32'(ins[24:20]);
      else r.b = 32'($signed(ins[31:20]));
      if (f3 == 1) r.ill = (f7 != 0);
      else if (f3 == 5) r.ill = !(f7 == 0 || f7 == 'h20);
      else r.ill = 0;
    end else if (opc == 'h37) begin
      r.b = ins & 32'hFFFF_F000; r.a2op = 3; r.rsel = 1; r.ill = 0;
    end else if (opc == 'h17) begin
      r.a = pc; r.b = ins & 32'hFFFF_F000; r.ill = 0;
    end
    if (arith) begin
      if (f3 == 0) r.alt = (opc == 'h33) && (f7 == 'h20 || ins[30]);
      if (f3 == 4) r.aop = 2;
      if (f3 == 6) r.aop = 3;
      if (f3 == 7) r.aop = 1;
      if (f3 == 1 || f3 == 2 || f3 == 3 || f3 == 5) r.rsel = 1;
      if (f3 == 2 || f3 == 3) r.a2op = 1;
      if (f3 == 5) r.a2op = 2;
      if (f3 == 2) r.alt2 = 1;
      if (f3 == 5) r.alt2 = ins[30];
    end
    r.wb = !r.ill && (r.rd != 0);
    return r;
  endfunction

  // One clock of stimulus; the model decides whether the offer is taken
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2, input bit ordy, input bit fl);
    bit exp_ready;
    @(posedge clk);
    #1;
    in_valid = v; in_instr = ins; in_pc = pc; rs1_data = r1; rs2_data = r2;
    out_ready = ordy; flush = fl;
    #2;
    exp_ready = (!exp_valid || ordy) && !fl;
    chk("in_ready", 128'(in_ready), 128'(exp_ready));
    chk("rs_addr", 128'({rs1_addr, rs2_addr}), 128'({ins[19:15], ins[24:20]}));
    acc_flag = v && exp_ready;
    if (acc_flag) exp_q.push_back(model(ins, pc, r1, r2));
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (exp_valid) begin
        chk("out_valid_hi", 128'(out_valid), 128'(1));
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL scoreboard_empty: got out_valid=%0d expected queued entry", out_valid);
        end else begin
          if (exp_q[0].ill)
            chk("illegal_beat", 128'({dut_res.rd, dut_res.wb, dut_res.ill, dut_res.pc}),
                128'({exp_q[0].rd, exp_q[0].wb, exp_q[0].ill, exp_q[0].pc}));
          else
            chk("beat", 128'(dut_res), 128'(exp_q[0]));
          if (out_ready || flush) void'(exp_q.pop_front());
        end
      end else begin
        chk("out_valid_lo", 128'(out_valid), 128'(0));
      end
      if (flush) exp_valid = 0;
      else if (acc_flag) exp_valid = 1;
      else if (out_ready) exp_valid = 0;
    end
  end

  initial begin
    logic [31:0] ins;
    logic [6:0]  opcs [5];
    opcs[0] = 7'h33; opcs[1] = 7'h13; opcs[2] = 7'h13; opcs[3] = 7'h37; opcs[4] = 7'h17;

    #12;
    chk("reset_out", 128'({out_valid, dut_res}), 128'(0));
    rst_n = 1'b1;
    mon_en = 1;

    // Directed cases
    step(1, 32'h002081B3, 32'h0000_0040, 32'd5, 32'd7, 1, 0);   // ADD
    step(1, 32'h402081B3, 32'h0000_0044, 32'd5, 32'd7, 1, 0);   // SUB
    step(1, 32'h40335293, 32'h0000_0048, 32'h8000_0000, 32'd1, 1, 0); // SRAI
    step(1, 32'h123450B7, 32'h0000_004C, 32'd9, 32'd9, 1, 0);   // LUI
    step(1, 32'h00001097, 32'h0000_0100, 32'd0, 32'd0, 1, 0);   // AUIPC
    step(1, 32'h0000006F, 32'h0000_0104, 32'd1, 32'd2, 1, 0);   // JAL: illegal
    step(1, 32'h0220C0B3, 32'h0000_0108, 32'd1, 32'd2, 1, 0);   // funct7 0000001: illegal
    step(1, 32'h00000013, 32'h0000_010C, 32'd0, 32'd0, 1, 0);   // ADDI x0: legal, no wb
    step(1, 32'h00C5F533, 32'h0000_0110, 32'hF0F0, 32'h0FF0, 1, 0); // AND
    // Backpressure for 3 cycles, then release with a new offer
    step(1, 32'h0062A3B3, 32'h0000_0114, 32'd3, 32'd4, 0, 0);
    step(1, 32'h0062A3B3, 32'h0000_0114, 32'd3, 32'd4, 0, 0);
    step(1, 32'h0062A3B3, 32'h0000_0114, 32'd3, 32'd4, 0, 0);
    step(1, 32'h0062A3B3, 32'h0000_0114, 32'd3, 32'd4, 1, 0);
    step(1, 32'h0062E3B3, 32'h0000_0118, 32'd3, 32'd4, 1, 0);
    // Flush while offering
    step(1, 32'h00A00093, 32'h0000_011C, 32'd0, 32'd0, 0, 1);
    step(0, 32'h0, 32'h0, 32'd0, 32'd0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      ins = $urandom;
      case ($urandom_range(0, 5))
        0, 1, 2, 3, 4: ins[6:0] = opcs[$urandom_range(0, 4)];
        default: ;
      endcase
      case ($urandom_range(0, 3))
        0, 1: ins[31:25] = 7'h00;
        2:    ins[31:25] = 7'h20;
        default: ;
      endcase
      step($urandom_range(0, 3) != 0, ins, $urandom, $urandom, $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset mid-stream with a beat held in the stage
    step(1, 32'h002081B3, 32'h0000_0200, 32'd1, 32'd2, 0, 0);
    step(1, 32'h002081B3, 32'h0000_0200, 32'd1, 32'd2, 0, 0);
    @(posedge clk);
    #2;
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 128'({out_valid, dut_res}), 128'(0));
    exp_q.delete();
    exp_valid = 0;
    acc_flag = 0;
    in_valid = 0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    mon_en = 1;

    step(1, 32'h40335293, 32'h0000_0300, 32'h8000_0000, 32'd0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 32'h0, 32'h0, 32'd0, 32'd0, 1, 0);
    chk("drained", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
